// File: rtl/sys1_upload_pkg.sv
// Shared types and constants for the System 1 HPS upload responder.
package sys1_upload_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_VB = 2'd1,
    REQ     = 2'd2
  } state_e;

  localparam logic [7:0] OOR_BYTE = 8'hFF;
  localparam int         CKSUM_W  = 16;

endpackage

// File: rtl/sys1_upload_if.sv
// HPS ioctl read channel plus the RAM second-port req/ack channel.
// The slave side is the upload server; the master side is the HPS and the RAM.
interface sys1_upload_if #(
  parameter int AW = 11
);
  logic          ioctl_upload;
  logic [7:0]    ioctl_index;
  logic          ioctl_rd;
  logic [24:0]   ioctl_addr;
  logic [7:0]    ioctl_din;
  logic          ioctl_wait;
  logic          ram_req;
  logic [AW-1:0] ram_addr;
  logic [7:0]    ram_dout;
  logic          ram_ack;

  modport slave (
    input  ioctl_upload, ioctl_index, ioctl_rd, ioctl_addr, ram_dout, ram_ack,
    output ioctl_din, ioctl_wait, ram_req, ram_addr
  );

  modport master (
    output ioctl_upload, ioctl_index, ioctl_rd, ioctl_addr, ram_dout, ram_ack,
    input  ioctl_din, ioctl_wait, ram_req, ram_addr
  );
endinterface

// File: rtl/sys1_upload_cksum.sv
// Running 16-bit sum of uploaded RAM bytes, cleared when an upload session starts.
// Only instantiated when SYS1_UPLOAD_CKSUM_EN is defined.
module sys1_upload_cksum
  import sys1_upload_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               upload_i,
  input  logic               add_en_i,
  input  logic [7:0]         byte_i,
  output logic [CKSUM_W-1:0] sum_o
);

  logic               upload_q;
  logic [CKSUM_W-1:0] sum_q, sum_d;

  // A new session wins over a coincident add; wraps naturally at 2^16.
  always_comb begin
    sum_d = sum_q;
    if (upload_i && !upload_q) begin
      sum_d = '0;
    end else if (add_en_i) begin
      sum_d = sum_q + CKSUM_W'(byte_i);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      upload_q <= 1'b0;
      sum_q    <= '0;
    end else begin
      upload_q <= upload_i;
      sum_q    <= sum_d;
    end
  end

  assign sum_o = sum_q;

endmodule

// File: rtl/sys1_upload_server.sv
// Serves HPS ioctl byte reads from System 1 work RAM, starting RAM accesses only in vblank.
// Optional checksum bytes at DEPTH/DEPTH+1 when SYS1_UPLOAD_CKSUM_EN is defined.
module sys1_upload_server
  import sys1_upload_pkg::*;
#(
  parameter int         AW    = 11,
  parameter int         DEPTH = 2048,
  parameter logic [7:0] IDX   = 8'd4
) (
  input logic           clk_sys,
  input logic           reset_n,
  input logic           vblank,
  sys1_upload_if.slave  bus
);

  localparam logic [24:0] DEPTH_A = 25'(DEPTH);

  state_e        state_q, state_d;
  logic [7:0]    din_q, din_d;
  logic          wait_q, wait_d;
  logic          req_q, req_d;
  logic [AW-1:0] addr_q, addr_d;

  logic          rd_hit;
  logic          in_range;
  logic [7:0]    oor_byte;

  assign rd_hit   = bus.ioctl_rd && bus.ioctl_upload && (bus.ioctl_index == IDX);
  assign in_range = bus.ioctl_addr < DEPTH_A;

`ifdef SYS1_UPLOAD_CKSUM_EN
  logic [CKSUM_W-1:0] sum;
  logic               ack_take;

  // Only acks that actually complete a read count; an aborted access does not.
  assign ack_take = (state_q == REQ) && bus.ioctl_upload && bus.ram_ack;

  sys1_upload_cksum u_cksum (
    .clk      (clk_sys),
    .rst_n    (reset_n),
    .upload_i (bus.ioctl_upload),
    .add_en_i (ack_take),
    .byte_i   (bus.ram_dout),
    .sum_o    (sum)
  );

  always_comb begin
    oor_byte = OOR_BYTE;
    if (bus.ioctl_addr == DEPTH_A) begin
      oor_byte = sum[7:0];
    end else if (bus.ioctl_addr == DEPTH_A + 25'd1) begin
      oor_byte = sum[15:8];
    end
  end
`else
  assign oor_byte = OOR_BYTE;
`endif

  // NOTE: every output of this block gets a default first, so no path leaves
  // a variable unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    din_d   = din_q;
    wait_d  = wait_q;
    req_d   = req_q;
    addr_d  = addr_q;
    unique case (state_q)
      IDLE: begin
        if (rd_hit) begin
          if (in_range) begin
            addr_d = bus.ioctl_addr[AW-1:0];
            wait_d = 1'b1;
            if (vblank) begin
              state_d = REQ;
              req_d   = 1'b1;
            end else begin
              state_d = WAIT_VB;
            end
          end else begin
            din_d = oor_byte;
          end
        end
      end
      WAIT_VB: begin
        if (!bus.ioctl_upload) begin
          state_d = IDLE;
          wait_d  = 1'b0;
        end else if (vblank) begin
          state_d = REQ;
          req_d   = 1'b1;
        end
      end
      REQ: begin
        // Once requested the access runs to its ack even if vblank ends.
        if (!bus.ioctl_upload) begin
          state_d = IDLE;
          req_d   = 1'b0;
          wait_d  = 1'b0;
        end else if (bus.ram_ack) begin
          state_d = IDLE;
          din_d   = bus.ram_dout;
          req_d   = 1'b0;
          wait_d  = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        req_d   = 1'b0;
        wait_d  = 1'b0;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of the others, independent of statement order.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      din_q   <= 8'h00;
      wait_q  <= 1'b0;
      req_q   <= 1'b0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      din_q   <= din_d;
      wait_q  <= wait_d;
      req_q   <= req_d;
      addr_q  <= addr_d;
    end
  end

  assign bus.ioctl_din  = din_q;
  assign bus.ioctl_wait = wait_q;
  assign bus.ram_req    = req_q;
  assign bus.ram_addr   = addr_q;

endmodule

// File: tb/tb_sys1_upload_server.sv
// Directed bench for sys1_upload_server: vector table plus hand sequences for
// vblank gating, abort, asynchronous reset and the optional checksum bytes.
module tb_sys1_upload_server;

  localparam int AW = 11;

  logic clk_sys = 1'b0;
  logic reset_n = 1'b0;
  logic vblank  = 1'b0;

  int n_checks = 0;
  int n_pass   = 0;

  sys1_upload_if #(.AW(AW)) bus ();

  sys1_upload_server #(.AW(AW), .DEPTH(2048), .IDX(8'd4)) dut (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .vblank  (vblank),
    .bus     (bus)
  );

  always #5 clk_sys = ~clk_sys;

  typedef struct {
    logic [24:0] addr;
    logic [7:0]  idx;
    logic        vb;
    logic [7:0]  ram_byte;
    logic        exp_wait;
    logic [7:0]  exp_din;
  } vec_t;

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else n_pass++;
  endtask

  task automatic pulse_ack(input logic [7:0] data);
    bus.ram_ack  = 1'b1;
    bus.ram_dout = data;
    tick();
    bus.ram_ack  = 1'b0;
    bus.ram_dout = 8'h00;
  endtask

  task automatic issue_rd(input logic [24:0] addr, input logic [7:0] idx);
    bus.ioctl_index = idx;
    bus.ioctl_addr  = addr;
    bus.ioctl_rd    = 1'b1;
    tick();
    bus.ioctl_rd    = 1'b0;
  endtask

  task automatic do_vec(input int n, input vec_t v);
    string tag;
    tag = $sformatf("vec%0d", n);
    vblank = v.vb;
    issue_rd(v.addr, v.idx);
    check({tag, "_wait_t1"}, 32'(bus.ioctl_wait), 32'(v.exp_wait));
    if (v.exp_wait) begin
      if (!v.vb) begin
        repeat (2) tick();
        check({tag, "_req_gated"}, 32'(bus.ram_req), 32'd0);
        vblank = 1'b1;
        tick();
      end
      check({tag, "_req"}, 32'(bus.ram_req), 32'd1);
      check({tag, "_ram_addr"}, 32'(bus.ram_addr), 32'(v.addr[AW-1:0]));
      tick();
      pulse_ack(v.ram_byte);
      check({tag, "_din"}, 32'(bus.ioctl_din), 32'(v.exp_din));
      check({tag, "_wait_done"}, 32'(bus.ioctl_wait), 32'd0);
      check({tag, "_req_done"}, 32'(bus.ram_req), 32'd0);
    end else begin
      check({tag, "_din"}, 32'(bus.ioctl_din), 32'(v.exp_din));
      check({tag, "_req_idle"}, 32'(bus.ram_req), 32'd0);
    end
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t vecs[8];
    logic [7:0] c_lo, c_hi, c_zero;

    bus.ioctl_upload = 1'b0;
    bus.ioctl_index  = 8'd0;
    bus.ioctl_rd     = 1'b0;
    bus.ioctl_addr   = '0;
    bus.ram_dout     = 8'h00;
    bus.ram_ack      = 1'b0;

`ifdef SYS1_UPLOAD_CKSUM_EN
    // Sum after 0x5A + 0xC3 = 0x011D.
    vecs[2] = '{25'h800, 8'd4, 1'b1, 8'h00, 1'b0, 8'h1D};
    vecs[3] = '{25'h801, 8'd4, 1'b1, 8'h00, 1'b0, 8'h01};
    c_lo = 8'h10; c_hi = 8'h01; c_zero = 8'h00;
`else
    vecs[2] = '{25'h800, 8'd4, 1'b1, 8'h00, 1'b0, 8'hFF};
    vecs[3] = '{25'h801, 8'd4, 1'b1, 8'h00, 1'b0, 8'hFF};
    c_lo = 8'hFF; c_hi = 8'hFF; c_zero = 8'hFF;
`endif
    vecs[0] = '{25'h010,     8'd4, 1'b1, 8'h5A, 1'b1, 8'h5A};
    vecs[1] = '{25'h7FF,     8'd4, 1'b0, 8'hC3, 1'b1, 8'hC3};
    vecs[4] = '{25'h802,     8'd4, 1'b1, 8'h00, 1'b0, 8'hFF};
    vecs[5] = '{25'h1000000, 8'd4, 1'b1, 8'h00, 1'b0, 8'hFF};
    vecs[6] = '{25'h020,     8'd3, 1'b1, 8'h99, 1'b0, 8'hFF};
    vecs[7] = '{25'h123,     8'd4, 1'b0, 8'h80, 1'b1, 8'h80};

    repeat (2) tick();
    check("rst_din", 32'(bus.ioctl_din), 32'd0);
    check("rst_wait", 32'(bus.ioctl_wait), 32'd0);
    check("rst_req", 32'(bus.ram_req), 32'd0);
    check("rst_addr", 32'(bus.ram_addr), 32'd0);
    reset_n = 1'b1;
    tick();
    bus.ioctl_upload = 1'b1;
    tick();

    for (int i = 0; i < 8; i++) do_vec(i, vecs[i]);

    // vblank gating, a stray rd while busy, and vblank falling mid-request
    vblank = 1'b0;
    issue_rd(25'h7FF, 8'd4);
    check("gate_wait", 32'(bus.ioctl_wait), 32'd1);
    issue_rd(25'h001, 8'd4);
    tick();
    check("gate_req_low", 32'(bus.ram_req), 32'd0);
    check("gate_addr_kept", 32'(bus.ram_addr), 32'h7FF);
    vblank = 1'b1;
    tick();
    check("gate_req_high", 32'(bus.ram_req), 32'd1);
    vblank = 1'b0;
    repeat (3) tick();
    check("gate_req_held", 32'(bus.ram_req), 32'd1);
    check("gate_wait_held", 32'(bus.ioctl_wait), 32'd1);
    pulse_ack(8'h3C);
    check("gate_din", 32'(bus.ioctl_din), 32'h3C);
    check("gate_wait_done", 32'(bus.ioctl_wait), 32'd0);

    // abort during REQ: late ack must not update din
    vblank = 1'b1;
    issue_rd(25'h055, 8'd4);
    check("abort_req", 32'(bus.ram_req), 32'd1);
    bus.ioctl_upload = 1'b0;
    tick();
    check("abort_req_low", 32'(bus.ram_req), 32'd0);
    check("abort_wait_low", 32'(bus.ioctl_wait), 32'd0);
    pulse_ack(8'h77);
    check("abort_din_kept", 32'(bus.ioctl_din), 32'h3C);
    bus.ioctl_upload = 1'b1;
    tick();

    // asynchronous reset while a request is pending
    issue_rd(25'h033, 8'd4);
    check("rreq_req", 32'(bus.ram_req), 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check("rreq_req_low", 32'(bus.ram_req), 32'd0);
    check("rreq_wait_low", 32'(bus.ioctl_wait), 32'd0);
    check("rreq_din_zero", 32'(bus.ioctl_din), 32'd0);
    tick();
    reset_n = 1'b1;
    tick();
    issue_rd(25'h044, 8'd4);
    check("rreq_next_req", 32'(bus.ram_req), 32'd1);
    check("rreq_next_addr", 32'(bus.ram_addr), 32'h044);
    pulse_ack(8'hA5);
    check("rreq_next_din", 32'(bus.ioctl_din), 32'hA5);

    // checksum: new session, bytes 0x01,0xFF,0x10 -> sum 0x0110
    bus.ioctl_upload = 1'b0;
    tick();
    bus.ioctl_upload = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      logic [7:0] b;
      b = (i == 0) ? 8'h01 : (i == 1) ? 8'hFF : 8'h10;
      issue_rd(25'(i), 8'd4);
      pulse_ack(b);
      check($sformatf("ck_byte%0d", i), 32'(bus.ioctl_din), 32'(b));
    end
    issue_rd(25'h800, 8'd4);
    check("ck_lo", 32'(bus.ioctl_din), 32'(c_lo));
    check("ck_lo_nowait", 32'(bus.ioctl_wait), 32'd0);
    issue_rd(25'h801, 8'd4);
    check("ck_hi", 32'(bus.ioctl_din), 32'(c_hi));
    issue_rd(25'h800, 8'd4);
    check("ck_lo_again", 32'(bus.ioctl_din), 32'(c_lo));
    issue_rd(25'h802, 8'd4);
    check("ck_beyond", 32'(bus.ioctl_din), 32'hFF);
    bus.ioctl_upload = 1'b0;
    tick();
    bus.ioctl_upload = 1'b1;
    tick();
    issue_rd(25'h800, 8'd4);
    check("ck_cleared", 32'(bus.ioctl_din), 32'(c_zero));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
